// File: rtl/mem_stage_pipe.sv
// EX/MEM register, data-memory access stage and MEM/WB register.
// Handshake: EX offers an instruction with ex_valid; it is taken on a cycle
// where ex_valid and ex_ready are both high. dmem_req is held until dmem_ready,
// and dmem_rdata is valid on the dmem_ready cycle.
// dbg_state exposes the access FSM (0 = S_RUN, 1 = S_WAIT).
module mem_stage_pipe #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic [4:0]      ex_rd_addr,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic            flush,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            EX_MEM_valid,
    output logic            EX_MEM_RegWrite,
    output logic [4:0]      EX_MEM_rd_addr,
    output logic [XLEN-1:0] EX_MEM_alu_result,
    output logic            MEM_WB_valid,
    output logic            MEM_WB_RegWrite,
    output logic [4:0]      MEM_WB_rd_addr,
    output logic [XLEN-1:0] MEM_WB_wdata,
    output logic            mem_err,
    output logic            dbg_state
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   wait_cnt, wait_cnt_next;

    logic            em_mem_read;
    logic            em_mem_write;
    logic [2:0]      em_funct3;
    logic [XLEN-1:0] em_store_data;

    logic            memop, aligned, retire, abort, wb_live;
    logic [XLEN-1:0] lane_word, load_data;

    // Access decode: alignment, retire/abort and the EX stall
    always_comb begin
        memop    = EX_MEM_valid & (em_mem_read | em_mem_write);
        aligned  = 1'b1;
        if (em_funct3[1:0] == 2'b01)
            aligned = (EX_MEM_alu_result[0] == 1'b0);
        else if (em_funct3[1:0] == 2'b10)
            aligned = (EX_MEM_alu_result[1:0] == 2'b00);
        retire   = EX_MEM_valid & (!memop | dmem_ready);
        abort    = (memop & !aligned) |
                   ((state == S_WAIT) & (wait_cnt == CW'(MEM_TIMEOUT)) & !dmem_ready);
        ex_ready = !flush & (!EX_MEM_valid | retire | abort);
        dmem_req = memop & aligned & !flush;
        wb_live  = retire & !flush & !abort;
    end

    // Memory-side store formatting and load lane extraction
    always_comb begin
        dmem_we    = em_mem_write;
        dmem_addr  = {EX_MEM_alu_result[XLEN-1:2], 2'b00};
        dmem_wstrb = 4'b1111;
        dmem_wdata = em_store_data;
        case (em_funct3[1:0])
            2'b00: begin
                dmem_wstrb = 4'b0001 << EX_MEM_alu_result[1:0];
                dmem_wdata = {(XLEN/8){em_store_data[7:0]}};
            end
            2'b01: begin
                dmem_wstrb = 4'b0011 << EX_MEM_alu_result[1:0];
                dmem_wdata = {(XLEN/16){em_store_data[15:0]}};
            end
            default: ;
        endcase
        lane_word = dmem_rdata >> {EX_MEM_alu_result[1:0], 3'b000};
        case (em_funct3)
            3'b000:  load_data = {{(XLEN-8){lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_data = {{(XLEN-16){lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, lane_word[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, lane_word[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // FSM next state: track how long an issued access has been waiting
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            S_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_next    = S_WAIT;
                    wait_cnt_next = CW'(1);
                end
            end
            S_WAIT: begin
                if (dmem_ready || flush || abort) begin
                    state_next    = S_RUN;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + CW'(1);
                end
            end
            default: begin
                state_next    = S_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    assign dbg_state = state;

    // EX/MEM register: load on handshake, clear on flush/retire/abort, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_MEM_valid      <= 1'b0;
            EX_MEM_RegWrite   <= 1'b0;
            EX_MEM_rd_addr    <= '0;
            EX_MEM_alu_result <= '0;
            em_mem_read       <= 1'b0;
            em_mem_write      <= 1'b0;
            em_funct3         <= '0;
            em_store_data     <= '0;
        end else if (flush) begin
            EX_MEM_valid      <= 1'b0;
        end else if (ex_valid && ex_ready) begin
            EX_MEM_valid      <= 1'b1;
            EX_MEM_RegWrite   <= ex_reg_write;
            EX_MEM_rd_addr    <= ex_rd_addr;
            EX_MEM_alu_result <= ex_alu_result;
            em_mem_read       <= ex_mem_read;
            em_mem_write      <= ex_mem_write;
            em_funct3         <= ex_funct3;
            em_store_data     <= ex_store_data;
        end else if (retire || abort) begin
            EX_MEM_valid      <= 1'b0;
        end
    end

    // MEM/WB register: advances every cycle; bubbles keep rd/wdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MEM_WB_valid    <= 1'b0;
            MEM_WB_RegWrite <= 1'b0;
            MEM_WB_rd_addr  <= '0;
            MEM_WB_wdata    <= '0;
            mem_err         <= 1'b0;
        end else begin
            MEM_WB_valid    <= wb_live;
            MEM_WB_RegWrite <= wb_live & EX_MEM_RegWrite;
            mem_err         <= abort;
            if (wb_live) begin
                MEM_WB_rd_addr <= EX_MEM_rd_addr;
                MEM_WB_wdata   <= em_mem_read ? load_data : EX_MEM_alu_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: ALU pass-through, loads, stores,
// misaligned abort, timeout abort, flush mid-wait and async reset mid-wait.
module tb_mem_stage_pipe;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid, ex_ready, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [2:0]      ex_funct3;
    logic [4:0]      ex_rd_addr;
    logic [XLEN-1:0] ex_alu_result, ex_store_data;
    logic            flush;
    logic            dmem_req, dmem_we, dmem_ready;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]      dmem_wstrb;
    logic            EX_MEM_valid, EX_MEM_RegWrite;
    logic [4:0]      EX_MEM_rd_addr;
    logic [XLEN-1:0] EX_MEM_alu_result;
    logic            MEM_WB_valid, MEM_WB_RegWrite;
    logic [4:0]      MEM_WB_rd_addr;
    logic [XLEN-1:0] MEM_WB_wdata;
    logic            mem_err, dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // expected write-back entries: {RegWrite, rd, wdata}
    logic [37:0] exp_q[$];

    mem_stage_pipe #(.XLEN(XLEN), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .ex_rd_addr(ex_rd_addr), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .EX_MEM_valid(EX_MEM_valid), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_rd_addr(EX_MEM_rd_addr), .EX_MEM_alu_result(EX_MEM_alu_result),
        .MEM_WB_valid(MEM_WB_valid), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_rd_addr(MEM_WB_rd_addr), .MEM_WB_wdata(MEM_WB_wdata),
        .mem_err(mem_err), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'b000;
        ex_rd_addr    = '0;
        ex_alu_result = '0;
        ex_store_data = '0;
    endtask

    task automatic issue(input logic rw, input logic mr, input logic mw,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd);
        ex_valid      = 1'b1;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_funct3     = f3;
        ex_rd_addr    = rd;
        ex_alu_result = alu;
        ex_store_data = sd;
    endtask

    // scoreboard: every live MEM/WB cycle must match the next expected entry
    always @(negedge clk) begin
        if (rst_n && MEM_WB_valid) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 32'(MEM_WB_valid), 32'd0);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                check("wb_regwrite", 32'(MEM_WB_RegWrite), 32'(e[37]));
                check("wb_rd", 32'(MEM_WB_rd_addr), 32'(e[36:32]));
                check("wb_wdata", MEM_WB_wdata, e[31:0]);
            end
        end
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_mem_valid", 32'(EX_MEM_valid), 32'd0);
        check("rst_mem_wb_valid", 32'(MEM_WB_valid), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        step();

        // ALU op rd=5 value 0x1234
        issue(1, 0, 0, 3'b000, 5'd5, 32'h1234, 0);
        exp_q.push_back({1'b1, 5'd5, 32'h1234});
        @(negedge clk);
        check("alu_ex_ready", 32'(ex_ready), 32'd1);
        step(); idle();
        @(negedge clk);
        check("alu_em_valid", 32'(EX_MEM_valid), 32'd1);
        check("alu_em_regwrite", 32'(EX_MEM_RegWrite), 32'd1);
        check("alu_em_rd", 32'(EX_MEM_rd_addr), 32'd5);
        check("alu_em_result", EX_MEM_alu_result, 32'h1234);
        check("alu_wb_not_yet", 32'(MEM_WB_valid), 32'd0);
        step();
        @(negedge clk);
        check("alu_wb_wdata", MEM_WB_wdata, 32'h1234);
        check("alu_em_drained", 32'(EX_MEM_valid), 32'd0);
        step();

        // LB 0x103, immediate ready
        issue(1, 1, 0, 3'b000, 5'd6, 32'h103, 0);
        exp_q.push_back({1'b1, 5'd6, 32'hFFFF_FF80});
        step(); idle();
        dmem_ready = 1'b1; dmem_rdata = 32'h80FF_FFFF;
        @(negedge clk);
        check("lb_req", 32'(dmem_req), 32'd1);
        check("lb_addr", dmem_addr, 32'h100);
        check("lb_we", 32'(dmem_we), 32'd0);
        check("lb_ex_ready", 32'(ex_ready), 32'd1);
        step(); dmem_ready = 1'b0;
        @(negedge clk);
        check("lb_wdata", MEM_WB_wdata, 32'hFFFF_FF80);
        step();

        // LHU 0x102 zero-extends upper half
        issue(1, 1, 0, 3'b101, 5'd13, 32'h102, 0);
        exp_q.push_back({1'b1, 5'd13, 32'h0000_8001});
        step(); idle();
        dmem_ready = 1'b1; dmem_rdata = 32'h8001_1234;
        @(negedge clk);
        check("lhu_ex_ready", 32'(ex_ready), 32'd1);
        step(); dmem_ready = 1'b0;

        // SB 0x101: byte replicated, lane 1
        issue(0, 0, 1, 3'b000, 5'd0, 32'h101, 32'h1234_5678);
        exp_q.push_back({1'b0, 5'd0, 32'h101});
        step(); idle();
        dmem_ready = 1'b1;
        @(negedge clk);
        check("sb_wstrb", 32'(dmem_wstrb), 32'h2);
        check("sb_wdata", dmem_wdata, 32'h7878_7878);
        check("sb_we", 32'(dmem_we), 32'd1);
        step(); dmem_ready = 1'b0;

        // SH 0x102, ready after 3 stall cycles, ALU op accepted on ready cycle
        issue(0, 0, 1, 3'b001, 5'd0, 32'h102, 32'h0000_ABCD);
        exp_q.push_back({1'b0, 5'd0, 32'h102});
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sh_stall", 32'(ex_ready), 32'd0);
            check("sh_req", 32'(dmem_req), 32'd1);
            check("sh_wstrb", 32'(dmem_wstrb), 32'hC);
            check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
            step();
        end
        dmem_ready = 1'b1;
        issue(1, 0, 0, 3'b000, 5'd7, 32'h55, 0);
        exp_q.push_back({1'b1, 5'd7, 32'h55});
        @(negedge clk);
        check("sh_ready_accept", 32'(ex_ready), 32'd1);
        check("sh_state_wait", 32'(dbg_state), 32'd1);
        step(); idle(); dmem_ready = 1'b0;
        @(negedge clk);
        check("b2b_em_rd", 32'(EX_MEM_rd_addr), 32'd7);
        check("b2b_em_result", EX_MEM_alu_result, 32'h55);
        check("b2b_state_run", 32'(dbg_state), 32'd0);
        step(); step();

        // LW 0x101 misaligned: never issued, error pulse, bubble
        issue(1, 1, 0, 3'b010, 5'd8, 32'h101, 0);
        step(); idle();
        @(negedge clk);
        check("mis_no_req", 32'(dmem_req), 32'd0);
        check("mis_ex_ready", 32'(ex_ready), 32'd1);
        step();
        @(negedge clk);
        check("mis_err", 32'(mem_err), 32'd1);
        check("mis_wb_bubble", 32'(MEM_WB_valid), 32'd0);
        check("mis_em_clear", 32'(EX_MEM_valid), 32'd0);
        step();
        @(negedge clk);
        check("mis_err_pulse", 32'(mem_err), 32'd0);
        step();

        // timeout: dmem_ready never arrives
        issue(1, 1, 0, 3'b010, 5'd9, 32'h200, 0);
        step(); idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_stall", 32'(ex_ready), 32'd0);
            check("to_req", 32'(dmem_req), 32'd1);
            step();
        end
        @(negedge clk);
        check("to_abort_ready", 32'(ex_ready), 32'd1);
        check("to_err_not_yet", 32'(mem_err), 32'd0);
        step();
        @(negedge clk);
        check("to_err", 32'(mem_err), 32'd1);
        check("to_em_clear", 32'(EX_MEM_valid), 32'd0);
        check("to_wb_bubble", 32'(MEM_WB_valid), 32'd0);
        check("to_req_drop", 32'(dmem_req), 32'd0);
        check("to_state_run", 32'(dbg_state), 32'd0);
        step();

        // flush during S_WAIT
        issue(1, 1, 0, 3'b010, 5'd10, 32'h300, 0);
        step(); idle();
        @(negedge clk);
        check("fl_req", 32'(dmem_req), 32'd1);
        step();
        flush = 1'b1;
        @(negedge clk);
        check("fl_state_wait", 32'(dbg_state), 32'd1);
        check("fl_ex_ready", 32'(ex_ready), 32'd0);
        step(); flush = 1'b0;
        @(negedge clk);
        check("fl_em_clear", 32'(EX_MEM_valid), 32'd0);
        check("fl_req_drop", 32'(dmem_req), 32'd0);
        check("fl_state_run", 32'(dbg_state), 32'd0);
        check("fl_wb_bubble", 32'(MEM_WB_valid), 32'd0);
        check("fl_no_err", 32'(mem_err), 32'd0);
        step();

        // async reset while a load waits, MEM/WB holding an ALU result
        issue(1, 0, 0, 3'b000, 5'd12, 32'hDEAD, 0);
        exp_q.push_back({1'b1, 5'd12, 32'hDEAD});
        step();
        issue(1, 1, 0, 3'b010, 5'd11, 32'h404, 0);
        @(negedge clk);
        check("rw_ex_ready", 32'(ex_ready), 32'd1);
        step(); idle();
        @(negedge clk);
        check("rw_req", 32'(dmem_req), 32'd1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("ar_em_valid", 32'(EX_MEM_valid), 32'd0);
        check("ar_wb_valid", 32'(MEM_WB_valid), 32'd0);
        check("ar_wb_wdata", MEM_WB_wdata, 32'd0);
        check("ar_wb_rd", 32'(MEM_WB_rd_addr), 32'd0);
        check("ar_req", 32'(dmem_req), 32'd0);
        check("ar_state", 32'(dbg_state), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
